// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the MEM/WB back-end of the 8-bit pipelined CPU:
// default datapath widths and the memory-control encoding that travels
// with each instruction from EX into MEM and WB.
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int REG_W  = 4;

    typedef enum logic [1:0] {
        MC_ALU = 2'b00,
        MC_ST  = 2'b01,
        MC_LD  = 2'b10,
        MC_NOP = 2'b11
    } mem_ctrl_e;

    // Only ALU results and load data ever reach the register file.
    function automatic logic ctrl_writes_reg(input mem_ctrl_e ctrl);
        return (ctrl == MC_ALU) || (ctrl == MC_LD);
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_ram.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_data_ram
// Single-port data RAM, 2**ADDR_W x DATA_W. Synchronous write, registered
// read. No reset: contents survive a pipeline reset.
// Ports:
//   clk    clock
//   we     write enable (write wdata to addr on rising edge)
//   re     read enable (capture mem[addr] into rdata on rising edge)
//   addr   shared read/write address
//   wdata  write data
//   rdata  registered read data (old contents on a same-edge write)
// ---------------------------------------------------------------------------
module mem_wb_stage_data_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM and WB back-end of the 8-bit pipelined CPU: EX/MEM register, data RAM,
// MEM/WB register, forwarding sources for the EX stage and the branch
// redirect/squash path.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall             hold both pipeline registers, block RAM write
//   ex_regwrt         EX instruction writes a register
//   ex_mem_ctrl       memory control (ALU / store / load / NOP)
//   ex_alu_result     ALU result, also the RAM address for load/store
//   ex_store_data     store data
//   ex_dest           destination register index
//   ex_branch_taken   branch condition hits, any bit set = taken
//   ex_branch_target  branch target PC
//   MEM_regwrt/data/dest  MEM-stage forwarding source (ALU ops only)
//   WB_regwrt/data/dest   regfile write port and WB forwarding source
//   mem_is_load       valid load in MEM, for the hazard unit
//   pc_redirect       load pc_target into the PC
//   pc_target         redirect address
//   flush             squash IF/ID, same as pc_redirect
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = mem_wb_stage_pkg::DATA_W,
    parameter int ADDR_W = mem_wb_stage_pkg::ADDR_W,
    parameter int REG_W  = mem_wb_stage_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              ex_regwrt,
    input  logic [1:0]        ex_mem_ctrl,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic [3:0]        ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic              MEM_regwrt,
    output logic [DATA_W-1:0] MEM_data,
    output logic [REG_W-1:0]  MEM_dest,
    output logic              WB_regwrt,
    output logic [DATA_W-1:0] WB_data,
    output logic [REG_W-1:0]  WB_dest,
    output logic              mem_is_load,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush
);

    // EX/MEM register
    logic              m_valid;
    logic              m_regwrt;
    mem_ctrl_e         m_ctrl;
    logic [DATA_W-1:0] m_alu;
    logic [DATA_W-1:0] m_store;
    logic [REG_W-1:0]  m_dest;
    logic [3:0]        m_taken;
    logic [ADDR_W-1:0] m_target;

    // MEM/WB register
    logic              w_valid;
    logic              w_regwrt;
    mem_ctrl_e         w_ctrl;
    logic [DATA_W-1:0] w_alu;
    logic [REG_W-1:0]  w_dest;

    logic              redirect;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // A taken branch in MEM redirects for exactly one cycle: the instruction
    // latched behind it is marked invalid, so it cannot redirect again.
    // During a stall m_* holds, so the redirect is held rather than repeated.
    assign redirect = m_valid & (|m_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_regwrt <= 1'b0;
            m_ctrl   <= MC_ALU;
            m_alu    <= '0;
            m_store  <= '0;
            m_dest   <= '0;
            m_taken  <= '0;
            m_target <= '0;
        end else if (!stall) begin
            m_valid  <= ~redirect;
            m_regwrt <= ex_regwrt;
            m_ctrl   <= mem_ctrl_e'(ex_mem_ctrl);
            m_alu    <= ex_alu_result;
            m_store  <= ex_store_data;
            m_dest   <= ex_dest;
            m_taken  <= ex_branch_taken;
            m_target <= ex_branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_valid  <= 1'b0;
            w_regwrt <= 1'b0;
            w_ctrl   <= MC_ALU;
            w_alu    <= '0;
            w_dest   <= '0;
        end else if (!stall) begin
            w_valid  <= m_valid;
            w_regwrt <= m_regwrt;
            w_ctrl   <= m_ctrl;
            w_alu    <= m_alu;
            w_dest   <= m_dest;
        end
    end

    // rst_n gates the write so a reset edge discards a store sitting in MEM.
    // The read register also holds under stall so WB_data stays frozen.
    assign ram_we = rst_n & ~stall & m_valid & (m_ctrl == MC_ST);
    assign ram_re = ~stall;

    mem_wb_stage_data_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (m_alu[ADDR_W-1:0]),
        .wdata (m_store),
        .rdata (ram_rdata)
    );

    // Load data is not available until WB, so MEM forwards ALU ops only.
    assign MEM_regwrt  = m_valid & m_regwrt & (m_ctrl == MC_ALU);
    assign MEM_data    = m_alu;
    assign MEM_dest    = m_dest;
    assign mem_is_load = m_valid & (m_ctrl == MC_LD);

    assign WB_regwrt   = w_valid & w_regwrt & ctrl_writes_reg(w_ctrl);
    assign WB_data     = (w_ctrl == MC_LD) ? ram_rdata : w_alu;
    assign WB_dest     = w_dest;

    assign pc_redirect = redirect;
    assign flush       = redirect;
    assign pc_target   = m_target;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       ex_regwrt;
    logic [1:0] ex_mem_ctrl;
    logic [7:0] ex_alu_result;
    logic [7:0] ex_store_data;
    logic [3:0] ex_dest;
    logic [3:0] ex_branch_taken;
    logic [7:0] ex_branch_target;
    logic       MEM_regwrt;
    logic [7:0] MEM_data;
    logic [3:0] MEM_dest;
    logic       WB_regwrt;
    logic [7:0] WB_data;
    logic [3:0] WB_dest;
    logic       mem_is_load;
    logic       pc_redirect;
    logic [7:0] pc_target;
    logic       flush;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .ex_regwrt        (ex_regwrt),
        .ex_mem_ctrl      (ex_mem_ctrl),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_dest          (ex_dest),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .MEM_regwrt       (MEM_regwrt),
        .MEM_data         (MEM_data),
        .MEM_dest         (MEM_dest),
        .WB_regwrt        (WB_regwrt),
        .WB_data          (WB_data),
        .WB_dest          (WB_dest),
        .mem_is_load      (mem_is_load),
        .pc_redirect      (pc_redirect),
        .pc_target        (pc_target),
        .flush            (flush)
    );

    typedef struct packed {
        logic       regwrt;
        logic [1:0] ctrl;
        logic [7:0] alu;
        logic [7:0] st;
        logic [3:0] dest;
        logic [3:0] taken;
        logic [7:0] target;
    } instr_t;

    typedef struct packed {
        logic       regwrt;
        logic [7:0] data;
        logic [3:0] dest;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    wb_exp_t     wb_last;
    logic [23:0] mem_last;
    logic [7:0]  ram_m [0:255];
    logic        prev_taken;
    logic        pend_we;
    logic [7:0]  pend_addr;
    logic [7:0]  pend_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] mem_vec();
        return {MEM_regwrt, MEM_data, MEM_dest, mem_is_load, pc_redirect, flush, pc_target};
    endfunction

    function automatic instr_t mk(input logic rw, input logic [1:0] c, input logic [7:0] a,
                                  input logic [7:0] s, input logic [3:0] d,
                                  input logic [3:0] tk, input logic [7:0] tg);
        instr_t i;
        i = '{regwrt: rw, ctrl: c, alu: a, st: s, dest: d, taken: tk, target: tg};
        return i;
    endfunction

    function automatic instr_t bubble();
        return mk(1'b0, 2'b11, 8'h00, 8'h00, 4'h0, 4'h0, 8'h00);
    endfunction

    task automatic drive(input instr_t i);
        ex_regwrt        = i.regwrt;
        ex_mem_ctrl      = i.ctrl;
        ex_alu_result    = i.alu;
        ex_store_data    = i.st;
        ex_dest          = i.dest;
        ex_branch_taken  = i.taken;
        ex_branch_target = i.target;
    endtask

    task automatic check_wb(input wb_exp_t e);
        check("wb_ctl", {WB_regwrt, WB_dest}, {e.regwrt, e.dest});
        if (e.regwrt) check("wb_data", WB_data, e.data);
    endtask

    // Issue one instruction; afterwards MEM holds it and WB holds the previous one.
    task automatic issue(input instr_t i);
        logic    v;
        wb_exp_t e;
        drive(i);
        stall = 1'b0;
        @(posedge clk);
        #1;
        if (pend_we) ram_m[pend_addr] = pend_data;
        pend_we = 1'b0;
        v = ~prev_taken;
        mem_last = {v & i.regwrt & (i.ctrl == 2'b00), i.alu, i.dest,
                    v & (i.ctrl == 2'b10), v & (|i.taken), v & (|i.taken), i.target};
        prev_taken = v & (|i.taken);
        if (v && i.ctrl == 2'b01) begin
            pend_we   = 1'b1;
            pend_addr = i.alu;
            pend_data = i.st;
        end
        e.regwrt = v & i.regwrt & ((i.ctrl == 2'b00) || (i.ctrl == 2'b10));
        e.data   = (i.ctrl == 2'b10) ? ram_m[i.alu] : i.alu;
        e.dest   = i.dest;
        check("mem", mem_vec(), mem_last);
        wb_q.push_back(e);
        if (wb_q.size() >= 2) begin
            wb_last = wb_q.pop_front();
            check_wb(wb_last);
        end
    endtask

    task automatic stall_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            stall = 1'b1;
            drive(mk(1'b1, 2'b01, 8'hFF, 8'hEE, 4'hF, 4'hF, 8'hFF));
            @(posedge clk);
            #1;
            check("stall_mem", mem_vec(), mem_last);
            check_wb(wb_last);
            if (pend_we) check("stall_ram", dut.u_ram.mem[pend_addr], ram_m[pend_addr]);
        end
        stall = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check("reset_out", {MEM_regwrt, MEM_data, MEM_dest, WB_regwrt, WB_data, WB_dest,
                                mem_is_load, pc_redirect, pc_target, flush}, 64'd0);
        end
        pend_we    = 1'b0;
        prev_taken = 1'b0;
        wb_q.delete();
        wb_last    = '0;
        mem_last   = '0;
        rst_n      = 1'b1;
    endtask

    initial begin
        logic [7:0] ra;
        int         r;
        rst_n = 1'b0;
        stall = 1'b0;
        drive(bubble());
        do_reset(2);

        // ALU op forwarded from MEM, then written back
        issue(mk(1'b1, 2'b00, 8'h3C, 8'h00, 4'd5, 4'h0, 8'h00));
        check("alu_mem", {MEM_regwrt, MEM_data, MEM_dest}, {1'b1, 8'h3C, 4'd5});
        // store then dependent load
        issue(mk(1'b0, 2'b01, 8'h10, 8'hA5, 4'd0, 4'h0, 8'h00));
        check("alu_wb", {WB_regwrt, WB_data, WB_dest}, {1'b1, 8'h3C, 4'd5});
        issue(mk(1'b1, 2'b10, 8'h10, 8'h00, 4'd2, 4'h0, 8'h00));
        check("ld_mem", {MEM_regwrt, mem_is_load}, 2'b01);
        issue(bubble());
        check("ld_wb", {WB_regwrt, WB_data, WB_dest}, {1'b1, 8'hA5, 4'd2});

        // branch squashes the following store
        issue(mk(1'b0, 2'b01, 8'h20, 8'h11, 4'd0, 4'h0, 8'h00));
        issue(mk(1'b0, 2'b00, 8'h00, 8'h00, 4'd0, 4'b1000, 8'h40));
        check("br_redir", {pc_redirect, flush, pc_target}, {1'b1, 1'b1, 8'h40});
        issue(mk(1'b0, 2'b01, 8'h20, 8'h77, 4'd0, 4'h0, 8'h00));
        check("br_one_cycle", {pc_redirect, flush}, 2'b00);
        issue(mk(1'b1, 2'b10, 8'h20, 8'h00, 4'd3, 4'h0, 8'h00));
        // NOP with regwrt set
        issue(mk(1'b1, 2'b11, 8'h99, 8'h00, 4'd7, 4'h0, 8'h00));
        check("nop_mem", MEM_regwrt, 1'b0);
        check("squash_ld", {WB_regwrt, WB_data, WB_dest}, {1'b1, 8'h11, 4'd3});
        issue(bubble());
        check("nop_wb", WB_regwrt, 1'b0);

        // stall with a store pending in MEM
        issue(mk(1'b0, 2'b01, 8'h30, 8'h33, 4'd0, 4'h0, 8'h00));
        issue(bubble());
        issue(mk(1'b0, 2'b01, 8'h30, 8'h5A, 4'd0, 4'h0, 8'h00));
        stall_cycles(3);
        issue(mk(1'b1, 2'b10, 8'h30, 8'h00, 4'd4, 4'h0, 8'h00));
        issue(bubble());
        check("stall_ld", {WB_regwrt, WB_data, WB_dest}, {1'b1, 8'h5A, 4'd4});
        issue(bubble());

        // reset while a store is in MEM
        issue(mk(1'b0, 2'b01, 8'h50, 8'h12, 4'd0, 4'h0, 8'h00));
        issue(bubble());
        issue(mk(1'b0, 2'b01, 8'h50, 8'hEE, 4'd0, 4'h0, 8'h00));
        do_reset(1);
        issue(mk(1'b1, 2'b10, 8'h50, 8'h00, 4'd6, 4'h0, 8'h00));
        issue(bubble());
        check("rst_ld", {WB_regwrt, WB_data, WB_dest}, {1'b1, 8'h12, 4'd6});

        // random mix over addresses already holding known data
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       ra = 8'h10;
                1:       ra = 8'h20;
                default: ra = 8'h30;
            endcase
            if (r <= 3)
                issue(mk(1'($urandom_range(0, 1)), 2'b00, 8'($urandom), 8'h00,
                         4'($urandom), 4'h0, 8'h00));
            else if (r == 4)
                issue(mk(1'($urandom_range(0, 1)), 2'b11, 8'($urandom), 8'h00,
                         4'($urandom), 4'h0, 8'h00));
            else if (r <= 6)
                issue(mk(1'b0, 2'b01, ra, 8'($urandom), 4'h0, 4'h0, 8'h00));
            else if (r <= 8)
                issue(mk(1'b1, 2'b10, ra, 8'h00, 4'($urandom), 4'h0, 8'h00));
            else
                issue(mk(1'b0, 2'b00, 8'h00, 8'h00, 4'h0, 4'($urandom_range(1, 15)),
                         8'($urandom)));
            if ($urandom_range(0, 7) == 0) stall_cycles(1);
        end
        for (int n = 0; n < 3; n++) issue(bubble());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
